seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Multi-cycle shift-add multiplier for the datapath's ALU stage. Latches two WIDTH-bit
//  operands on start, iterates one bit per cycle, and presents a 2*WIDTH-bit product.
//  product_lo drives one data input of the 4:1 result-select mux; product_hi goes to
//  the HI register path. start/busy/done handshake with the multi-cycle controller.
// PARAMETERS
//  WIDTH   16   operand width; product is 2*WIDTH bits; must be >= 2
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  start       in   1      request; sampled only in IDLE or DONE
//  operand_a   in   WIDTH  multiplicand, captured on accepted start
//  operand_b   in   WIDTH  multiplier, captured on accepted start
//  busy        out  1      high while in RUN
//  done        out  1      one-cycle pulse, product valid from this cycle
//  product_lo  out  WIDTH  product[WIDTH-1:0], registered
//  product_hi  out  WIDTH  product[2*WIDTH-1:WIDTH], registered
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): state=IDLE; busy=0, done=0, product_lo/hi=0,
//    count=0, internal acc/multiplier regs=0. Overrides start and any run in progress.
//  - States: IDLE -> RUN on start; RUN -> DONE when count reaches 0; DONE -> RUN if start,
//    else IDLE. A start in DONE is accepted back-to-back (no idle bubble).
//  - Accept: mcand<=operand_a, mplier<=operand_b, acc<=0, count<=WIDTH, busy<=1.
//  - RUN step per cycle: sum = acc + (mplier[0] ? mcand : 0) in WIDTH+1 bits (carry kept);
//    {acc, mplier} <= {sum, mplier} >> 1; count <= count-1. Exactly WIDTH steps.
//  - After step WIDTH: product_hi<=acc, product_lo<=mplier, busy<=0, done<=1 (DONE state).
//  - Latency: start sampled at edge N -> done=1 after edge N+WIDTH+1 (17 for WIDTH=16).
//  - product_lo/hi change only on the completing edge; held stable through IDLE until the
//    next run completes (stay old value while busy).
//  - start while busy (RUN): ignored; operands not re-sampled; no queuing.
//  - done is never high together with busy. No overflow: full 2*WIDTH result always exact.
// CONFIGURATION
//  SEQ_MUL_SIGNED_EN defined: extra input port is_signed (1 bit, after operand_b),
//    captured with operands. If 1: operands treated two's complement; magnitudes are
//    multiplied; product negated (2*WIDTH-bit two's complement) on the completing edge if
//    operand signs differ. Latency unchanged. is_signed=0 gives unsigned result.
//  Not defined: no is_signed port; unsigned only; no negation logic synthesised.
// TESTING
//  1. rst 2 cycles -> busy=0,done=0,product=0; start a=3,b=5 -> done after 17 edges, lo=0x000F,hi=0.
//  2. a=0xFFFF,b=0xFFFF unsigned -> lo=0x0001, hi=0xFFFE (carry path exercised).
//  3. a=0x1234,b=0 -> product 0; then start held in DONE with a=2,b=7 -> back-to-back run, lo=0x000E.
//  4. start a=9,b=9; pulse start a=1,b=1 at cycle 5 of RUN -> ignored, lo=0x0051.
//  5. rst asserted at RUN cycle 8 -> next edge busy=0,done=0,product=0, state IDLE; new start works.
//  6. SEQ_MUL_SIGNED_EN, is_signed=1: a=0xFFFD(-3),b=5 -> {hi,lo}=0xFFFFFFF1; a=b=0x8000 -> 0x40000000.

Source files
------------

// File: rtl/seq_mul_if.sv
// Handshake and operand/product bundle between the multi-cycle controller and seq_multiplier.
// SEQ_MUL_SIGNED_EN adds the is_signed request bit.
interface seq_mul_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
`ifdef SEQ_MUL_SIGNED_EN
  logic             is_signed;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;

`ifdef SEQ_MUL_SIGNED_EN
  modport master (
    output start, operand_a, operand_b, is_signed,
    input  busy, done, product_lo, product_hi
  );
  modport slave (
    input  start, operand_a, operand_b, is_signed,
    output busy, done, product_lo, product_hi
  );
`else
  modport master (
    output start, operand_a, operand_b,
    input  busy, done, product_lo, product_hi
  );
  modport slave (
    input  start, operand_a, operand_b,
    output busy, done, product_lo, product_hi
  );
`endif
endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, one multiplier bit per cycle, registered 2*WIDTH-bit product.
// SEQ_MUL_SIGNED_EN enables two's complement operands via the is_signed request bit.
module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input logic     clk,
  input logic     rst,
  seq_mul_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0] a_in, b_in;
`ifdef SEQ_MUL_SIGNED_EN
  logic             neg_q, neg_d;
`endif

  // Signed requests iterate on magnitudes; the sign is re-applied on completion.
`ifdef SEQ_MUL_SIGNED_EN
  assign a_in = (bus.is_signed && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
  assign b_in = (bus.is_signed && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
  assign result = neg_q ? -{acc_q, mplier_q} : {acc_q, mplier_q};
`else
  assign a_in = bus.operand_a;
  assign b_in = bus.operand_b;
  assign result = {acc_q, mplier_q};
`endif

  assign sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    count_d   = count_q;
`ifdef SEQ_MUL_SIGNED_EN
    neg_d     = neg_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d  = StRun;
          mcand_d  = a_in;
          mplier_d = b_in;
          acc_d    = '0;
          count_d  = CntW'(WIDTH);
`ifdef SEQ_MUL_SIGNED_EN
          neg_d    = bus.is_signed && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (count_q == '0) begin
          state_d   = StDone;
          prod_hi_d = result[2*WIDTH-1:WIDTH];
          prod_lo_d = result[WIDTH-1:0];
        end else begin
          acc_d    = sum[WIDTH:1];
          mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
          count_d  = count_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      count_q   <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
      count_q   <= count_d;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign bus.busy       = (state_q == StRun);
  assign bus.done       = (state_q == StDone);
  assign bus.product_lo = prod_lo_q;
  assign bus.product_hi = prod_hi_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random bench for seq_multiplier against an arithmetic reference model.
module tb_seq_multiplier;
  localparam int unsigned W = 16;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [2*W-1:0] last_prod;

  seq_mul_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic signed [2*W-1:0] sa, sb;
    logic signed [2*W-1:0] sp;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      sp = sa * sb;
      return sp;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // kind 0: plain run; 1: start pulse at RUN cycle 5; 2: reset at RUN cycle 8.
  // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge showing done.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int kind);
    logic [2*W-1:0] exp;
    int edges;
    exp = model(a, b, s);
    bus.start     = 1'b1;
    bus.operand_a = a;
    bus.operand_b = b;
`ifdef SEQ_MUL_SIGNED_EN
    bus.is_signed = s;
`endif
    @(negedge clk);
    bus.start     = 1'b0;
    bus.operand_a = W'($urandom);
    bus.operand_b = W'($urandom);
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("done_low_in_run", 64'(bus.done), 64'd0);
    edges = 0;
    while (!bus.done && edges < 40) begin
      @(negedge clk);
      edges++;
      bus.start = (kind == 1 && edges == 5);
      if (kind == 1 && edges == 5) begin
        bus.operand_a = 16'd1;
        bus.operand_b = 16'd1;
        check("product_held_while_busy", 64'({bus.product_hi, bus.product_lo}), 64'(last_prod));
      end
      if (kind == 2 && edges == 8) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_product", 64'({bus.product_hi, bus.product_lo}), 64'd0);
        last_prod = '0;
        return;
      end
    end
    check("latency", 64'(edges), 64'd17);
    check("busy_low_at_done", 64'(bus.busy), 64'd0);
    check("product", 64'({bus.product_hi, bus.product_lo}), 64'(exp));
    last_prod = exp;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    check("idle_done", 64'(bus.done), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_product_stable", 64'({bus.product_hi, bus.product_lo}), 64'(last_prod));
  endtask

  initial begin
    logic s;
    tests         = 0;
    fails         = 0;
    last_prod     = '0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
`ifdef SEQ_MUL_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", 64'({bus.product_hi, bus.product_lo}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(16'd3, 16'd5, 1'b0, 0);
    check("lo_3x5", 64'(bus.product_lo), 64'h000F);
    idle(2);
    launch(16'hFFFF, 16'hFFFF, 1'b0, 0);
    check("hi_ffff_sq", 64'(bus.product_hi), 64'hFFFE);
    check("lo_ffff_sq", 64'(bus.product_lo), 64'h0001);
    idle(1);
    launch(16'h1234, 16'h0000, 1'b0, 0);
    launch(16'd2, 16'd7, 1'b0, 0);
    check("lo_back_to_back", 64'(bus.product_lo), 64'h000E);
    idle(2);
    launch(16'd9, 16'd9, 1'b0, 1);
    check("lo_start_ignored", 64'(bus.product_lo), 64'h0051);
    idle(1);
    launch(16'hABCD, 16'h1357, 1'b0, 2);
    idle(1);
    launch(16'd3, 16'd5, 1'b0, 0);
    idle(1);
`ifdef SEQ_MUL_SIGNED_EN
    launch(16'hFFFD, 16'd5, 1'b1, 0);
    check("signed_neg3x5", 64'({bus.product_hi, bus.product_lo}), 64'hFFFFFFF1);
    launch(16'h8000, 16'h8000, 1'b1, 0);
    check("signed_min_sq", 64'({bus.product_hi, bus.product_lo}), 64'h40000000);
    launch(16'hFFFD, 16'd5, 1'b0, 0);
    idle(1);
`endif

    for (int i = 0; i < 24; i++) begin
`ifdef SEQ_MUL_SIGNED_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      launch(W'($urandom), W'($urandom), s, 0);
      if ($urandom_range(1, 0) == 1) idle(1 + $urandom_range(2, 0));
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
